// File: rtl/sign_calc_pkg.sv
// Shared mode and state encodings for the sequential sign-magnitude calculator.
package sign_calc_pkg;

    localparam logic [1:0] MODE_ADD = 2'b00;
    localparam logic [1:0] MODE_SUB = 2'b01;
    localparam logic [1:0] MODE_MUL = 2'b10;
    localparam logic [1:0] MODE_DIV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_EXEC = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/sign_calc_muldiv.sv
// Unsigned iterative core: shift-add multiply or restoring divide, one bit per cycle.
// The first step is applied on the start edge, so W steps finish W edges after start.
module sign_calc_muldiv #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           op_div,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] product,
    output logic [W-1:0]   quotient,
    output logic [W-1:0]   remainder
);

    localparam int CW = $clog2(W + 1);

    // hi/lo hold {partial product, multiplier} for mul and {remainder, quotient} for div
    logic [W:0]    hi;
    logic [W-1:0]  lo;
    logic [W-1:0]  b_q;
    logic          div_q;
    logic [CW-1:0] cnt;

    logic [W:0]    hi_src;
    logic [W-1:0]  lo_src;
    logic [W-1:0]  b_src;
    logic          div_src;
    logic [W:0]    hi_nxt;
    logic [W-1:0]  lo_nxt;
    logic [W:0]    sum;
    logic [W:0]    shifted;
    logic [W:0]    diff;
    logic          ge;

    always_comb begin
        hi_src  = hi;
        lo_src  = lo;
        b_src   = b_q;
        div_src = div_q;
        if (start) begin
            hi_src  = '0;
            lo_src  = a;
            b_src   = b;
            div_src = op_div;
        end

        sum     = hi_src + (lo_src[0] ? {1'b0, b_src} : '0);
        shifted = {hi_src[W-1:0], lo_src[W-1]};
        diff    = shifted - {1'b0, b_src};
        ge      = (shifted >= {1'b0, b_src});

        if (div_src) begin
            hi_nxt = ge ? diff : shifted;
            lo_nxt = {lo_src[W-2:0], ge};
        end else begin
            hi_nxt = {1'b0, sum[W:1]};
            lo_nxt = {sum[0], lo_src[W-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi    <= '0;
            lo    <= '0;
            b_q   <= '0;
            div_q <= 1'b0;
            cnt   <= '0;
            done  <= 1'b0;
        end else if (start) begin
            hi    <= hi_nxt;
            lo    <= lo_nxt;
            b_q   <= b;
            div_q <= op_div;
            cnt   <= CW'(W - 1);
            done  <= 1'b0;
        end else if (cnt != '0) begin
            hi   <= hi_nxt;
            lo   <= lo_nxt;
            cnt  <= cnt - 1'b1;
            done <= (cnt == CW'(1));
        end else begin
            done <= 1'b0;
        end
    end

    assign busy      = (cnt != '0);
    assign product   = {hi[W-1:0], lo};
    assign quotient  = lo;
    assign remainder = hi[W-1:0];

endmodule

// File: rtl/sign_calc_seq.sv
// Handshaked sign-magnitude calculator (add/sub/mul/div) with two's-complement result.
// Define SIGN_CALC_REM_EN to add the signed division remainder port Rem_out.
module sign_calc_seq
    import sign_calc_pkg::*;
#(
    parameter  int W     = 4,
    localparam int OUT_W = 2 * W + 1
) (
    input  logic                    clk,
    input  logic                    Clear_n,
    input  logic                    In_valid,
    output logic                    In_ready,
    input  logic [W-1:0]            A,
    input  logic [W-1:0]            B,
    input  logic [1:0]              S,
    input  logic [1:0]              M,
    output logic                    Out_valid,
    input  logic                    Out_ready,
    output logic signed [OUT_W-1:0] Cal_out,
    output logic                    Div_zero
`ifdef SIGN_CALC_REM_EN
    ,
    output logic signed [W:0]       Rem_out
`endif
);

    function automatic logic signed [OUT_W-1:0] apply_sign(input logic [OUT_W-1:0] mag,
                                                           input logic neg);
        return neg ? -$signed(mag) : $signed(mag);
    endfunction

`ifdef SIGN_CALC_REM_EN
    function automatic logic signed [W:0] apply_sign_rem(input logic [W-1:0] mag,
                                                         input logic neg);
        logic signed [W:0] m;
        m = $signed({1'b0, mag});
        return neg ? -m : m;
    endfunction
`endif

    state_t state, nxt;

    logic [W-1:0]            a_q, b_q;
    logic [1:0]              s_q, m_q;
    logic signed [OUT_W-1:0] op_a, op_b;

    logic                    md_start, md_busy, md_done;
    logic [2*W-1:0]          md_prod;
    logic [W-1:0]            md_quo;
    logic                    exec_fin;
    logic signed [OUT_W-1:0] res_c;
    logic                    dz_c;

`ifdef SIGN_CALC_REM_EN
    logic [W-1:0]            md_rem;
    logic signed [W:0]       rem_c;
`else
    logic [W-1:0]            md_rem_unused;
`endif

    assign md_start = (state == ST_LOAD) && m_q[1];

    sign_calc_muldiv #(.W(W)) u_muldiv (
        .clk       (clk),
        .rst_n     (Clear_n),
        .start     (md_start),
        .op_div    (m_q[0]),
        .a         (a_q),
        .b         (b_q),
        .busy      (md_busy),
        .done      (md_done),
        .product   (md_prod),
        .quotient  (md_quo),
`ifdef SIGN_CALC_REM_EN
        .remainder (md_rem)
`else
        .remainder (md_rem_unused)
`endif
    );

    // add/sub leave EXEC after one cycle; mul/div wait for the core
    assign exec_fin  = (state == ST_EXEC) && (!m_q[1] || md_done);
    assign In_ready  = (state == ST_IDLE) && !md_busy;
    assign Out_valid = (state == ST_DONE);

    always_ff @(posedge clk or negedge Clear_n) begin
        if (!Clear_n) state <= ST_IDLE;
        else          state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE: if (In_valid)  nxt = ST_LOAD;
            ST_LOAD:                nxt = ST_EXEC;
            ST_EXEC: if (exec_fin)  nxt = ST_DONE;
            ST_DONE: if (Out_ready) nxt = ST_IDLE;
            default:                nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        res_c = '0;
        dz_c  = 1'b0;
`ifdef SIGN_CALC_REM_EN
        rem_c = '0;
`endif
        case (m_q)
            MODE_ADD: res_c = op_a + op_b;
            MODE_SUB: res_c = op_a - op_b;
            MODE_MUL: res_c = apply_sign({1'b0, md_prod}, s_q[0] ^ s_q[1]);
            default: begin
                if (b_q == '0) begin
                    dz_c = 1'b1;
                end else begin
                    res_c = apply_sign(OUT_W'(md_quo), s_q[0] ^ s_q[1]);
`ifdef SIGN_CALC_REM_EN
                    rem_c = apply_sign_rem(md_rem, s_q[0]);
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge Clear_n) begin
        if (!Clear_n) begin
            a_q      <= '0;
            b_q      <= '0;
            s_q      <= '0;
            m_q      <= '0;
            op_a     <= '0;
            op_b     <= '0;
            Cal_out  <= '0;
            Div_zero <= 1'b0;
`ifdef SIGN_CALC_REM_EN
            Rem_out  <= '0;
`endif
        end else begin
            if (state == ST_IDLE && In_valid) begin
                a_q <= A;
                b_q <= B;
                s_q <= S;
                m_q <= M;
            end
            if (state == ST_LOAD) begin
                op_a <= apply_sign(OUT_W'(a_q), s_q[0]);
                op_b <= apply_sign(OUT_W'(b_q), s_q[1]);
            end
            if (exec_fin) begin
                Cal_out  <= res_c;
                Div_zero <= dz_c;
`ifdef SIGN_CALC_REM_EN
                Rem_out  <= rem_c;
`endif
            end
            // Cal_out deliberately keeps its value after the handshake
            if (state == ST_DONE && Out_ready) begin
                Div_zero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sign_calc_seq.sv
// Directed bench for sign_calc_seq (W=4); latency counts the accept edge as cycle 1.
module tb_sign_calc_seq;

    localparam int W     = 4;
    localparam int OUT_W = 2 * W + 1;

    logic                    clk = 1'b0;
    logic                    Clear_n;
    logic                    In_valid;
    logic                    In_ready;
    logic [W-1:0]            A;
    logic [W-1:0]            B;
    logic [1:0]              S;
    logic [1:0]              M;
    logic                    Out_valid;
    logic                    Out_ready;
    logic signed [OUT_W-1:0] Cal_out;
    logic                    Div_zero;
`ifdef SIGN_CALC_REM_EN
    logic signed [W:0]       Rem_out;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    sign_calc_seq #(.W(W)) dut (
        .clk       (clk),
        .Clear_n   (Clear_n),
        .In_valid  (In_valid),
        .In_ready  (In_ready),
        .A         (A),
        .B         (B),
        .S         (S),
        .M         (M),
        .Out_valid (Out_valid),
        .Out_ready (Out_ready),
        .Cal_out   (Cal_out),
        .Div_zero  (Div_zero)
`ifdef SIGN_CALC_REM_EN
        ,
        .Rem_out   (Rem_out)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int cal();
        return int'($signed(Cal_out));
    endfunction

    // Present one operand set for a single accept edge, then scramble the ports
    task automatic start_op(input int a, input int sa, input int b, input int sb, input int m);
        A        = 4'(a);
        B        = 4'(b);
        S        = {1'(sb), 1'(sa)};
        M        = 2'(m);
        In_valid = 1'b1;
        tick();
        In_valid = 1'b0;
        A        = 4'hA;
        B        = 4'h5;
        S        = 2'b10;
        M        = 2'b01;
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        int cycles;
        cycles = 1;
        while (Out_valid !== 1'b1 && cycles < 40) begin
            tick();
            cycles++;
        end
        chk({tag, "_lat"}, cycles, exp_lat);
    endtask

    task automatic handshake(input string tag);
        Out_ready = 1'b1;
        tick();
        Out_ready = 1'b0;
        chk({tag, "_ovld_clr"}, int'(Out_valid), 0);
        chk({tag, "_irdy"}, int'(In_ready), 1);
    endtask

    initial begin
        Clear_n   = 1'b0;
        In_valid  = 1'b0;
        Out_ready = 1'b0;
        A = '0; B = '0; S = '0; M = '0;
        tick();
        tick();
        chk("rst_irdy", int'(In_ready), 1);
        chk("rst_ovld", int'(Out_valid), 0);
        chk("rst_cal",  cal(), 0);
        chk("rst_dz",   int'(Div_zero), 0);
        Clear_n = 1'b1;
        tick();

        // -5 + 3
        start_op(5, 1, 3, 0, 0);
        chk("add_busy_irdy", int'(In_ready), 0);
        wait_done("add", 3);
        chk("add_cal", cal(), -2);
        chk("add_dz",  int'(Div_zero), 0);
        handshake("add");

        // 3 - 7 and -2 - (-5)
        start_op(3, 0, 7, 0, 1);
        wait_done("sub1", 3);
        chk("sub1_cal", cal(), -4);
        handshake("sub1");
        start_op(2, 1, 5, 1, 1);
        wait_done("sub2", 3);
        chk("sub2_cal", cal(), 3);
        handshake("sub2");

        // (-15) * (-15) and (-15) * 15
        start_op(15, 1, 15, 1, 2);
        wait_done("mul1", 6);
        chk("mul1_cal", cal(), 225);
        handshake("mul1");
        start_op(15, 1, 15, 0, 2);
        wait_done("mul2", 6);
        chk("mul2_cal", cal(), -225);
        handshake("mul2");
        start_op(0, 1, 5, 0, 2);
        wait_done("mul0", 6);
        chk("mul0_cal", cal(), 0);
        handshake("mul0");

        // -7 / 2, -0 / 3, 13 / -4
        start_op(7, 1, 2, 0, 3);
        wait_done("div1", 6);
        chk("div1_cal", cal(), -3);
        chk("div1_dz",  int'(Div_zero), 0);
`ifdef SIGN_CALC_REM_EN
        chk("div1_rem", int'(Rem_out), -1);
`endif
        handshake("div1");
        start_op(0, 1, 3, 0, 3);
        wait_done("div0n", 6);
        chk("div0n_cal", cal(), 0);
        handshake("div0n");
        start_op(13, 0, 4, 1, 3);
        wait_done("div2", 6);
        chk("div2_cal", cal(), -3);
`ifdef SIGN_CALC_REM_EN
        chk("div2_rem", int'(Rem_out), 1);
`endif
        handshake("div2");

        // 9 / 0, then 1 + 1
        start_op(9, 0, 0, 0, 3);
        wait_done("dz", 6);
        chk("dz_flag", int'(Div_zero), 1);
        chk("dz_cal",  cal(), 0);
`ifdef SIGN_CALC_REM_EN
        chk("dz_rem", int'(Rem_out), 0);
`endif
        handshake("dz");
        chk("dz_flag_clr", int'(Div_zero), 0);
        start_op(1, 0, 1, 0, 0);
        wait_done("after_dz", 3);
        chk("after_dz_flag", int'(Div_zero), 0);
        chk("after_dz_cal",  cal(), 2);
        handshake("after_dz");

        // Stall in DONE with a competing In_valid: nothing moves, nothing queued
        start_op(3, 0, 4, 0, 2);
        wait_done("hold", 6);
        In_valid = 1'b1;
        A = 4'd15; B = 4'd15; M = 2'b00; S = 2'b00;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_ovld", int'(Out_valid), 1);
            chk("hold_cal",  cal(), 12);
            chk("hold_irdy", int'(In_ready), 0);
        end
        In_valid = 1'b0;
        handshake("hold");
        chk("hold_cal_kept", cal(), 12);
        for (int i = 0; i < 4; i++) tick();
        chk("hold_no_queue", int'(Out_valid), 0);

        // Async reset mid-EXEC of a multiply
        start_op(15, 0, 15, 0, 2);
        tick();
        tick();
        chk("mid_busy", int'(In_ready), 0);
        Clear_n = 1'b0;
        #1;
        chk("mid_rst_ovld", int'(Out_valid), 0);
        chk("mid_rst_irdy", int'(In_ready), 1);
        chk("mid_rst_cal",  cal(), 0);
        tick();
        Clear_n = 1'b1;
        tick();
        chk("mid_rst_no_out", int'(Out_valid), 0);
        start_op(6, 0, 4, 1, 1);
        wait_done("post_rst", 3);
        chk("post_rst_cal", cal(), 10);
        handshake("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sign_calc_seq.md
Name: sign_calc_seq

Overview:
- Parametrised, handshaked successor to the team's fixed 4-bit sign calculator.
- Accepts two sign-magnitude operands of width W, each with a sign bit, plus a 2-bit mode: add, sub, mul or div.
- Returns a two's-complement result.
- Add/sub are single-cycle; mul/div are iterative shift-add / restoring, one bit per cycle.
- Sits between the operand-entry front end and the display/output stage.

Parameters:
- W, 4, operand magnitude width (2..16).
- OUT_W, 2*W+1, result width; derived, not overridable.

Ports:
- clk  in  1  rising-edge clock.
- Clear_n  in  1  asynchronous active-low reset.
- In_valid  in  1  operand set valid.
- In_ready  out  1  block idle, can accept.
- A  in  W  magnitude of operand A.
- B  in  W  magnitude of operand B.
- S  in  2  signs: S[0]=1 negates A, S[1]=1 negates B.
- M  in  2  mode: 00 add, 01 sub (A-B), 10 mul, 11 div (A/B).
- Out_valid  out  1  result valid; held until accepted.
- Out_ready  in  1  downstream accepts.
- Cal_out  out  OUT_W  signed result.
- Div_zero  out  1  qualified by Out_valid; M=11 and B=0.

Behaviour:
- Reset (Clear_n low, async): state IDLE, In_ready=1, Out_valid=0, Cal_out=0, Div_zero=0, all internal registers 0. Any in-flight op is discarded, no output produced.
- States: IDLE, LOAD, EXEC, DONE.
- IDLE: In_ready=1. On In_valid: latch A,B,S,M, go to LOAD. In_ready is low in every other state.
- LOAD: convert each operand to OUT_W two's complement (negate if its sign bit is set); load the iteration counter with W.
  - M=00/01 -> EXEC for 1 cycle.
  - M=10/11 -> EXEC for W cycles.
- EXEC:
  - add/sub: full-width OUT_W arithmetic; cannot overflow.
  - mul: unsigned |A|*|B| by W shift-add steps; result sign = S[0]^S[1].
  - div: unsigned restoring division, W steps. Quotient truncates toward zero; sign = S[0]^S[1].
  - Zero magnitude always gives +0; no negative zero in any mode.
  - B=0 with M=11: Div_zero=1, Cal_out=0, still W cycles (fixed latency).
- DONE: Out_valid=1, Cal_out/Div_zero stable. On Out_ready: Out_valid->0, Div_zero->0, go to IDLE. Cal_out holds its last value.
- Latency, accept edge to Out_valid: add/sub 3 cycles; mul/div W+2 cycles.
- Back-to-back: next In_valid is accepted the cycle after the DONE handshake; one op in flight max.
- In_valid while busy: ignored, not queued.
- Out_ready while not in DONE: no effect.
- Operand ports may change after acceptance without effect.
- No $display in synthesisable path.

Optional Feature:
- Macro: SIGN_CALC_REM_EN.
- Defined: adds port Rem_out (out, W+1, signed) with the division remainder.
  - Remainder takes the dividend's sign; |Rem_out| < |B|.
  - Rem_out is 0 for non-div modes and for Div_zero.
  - Same valid/hold rules as Cal_out; reset value 0.
- Undefined: port absent; remainder register not built.

Decomposition:
- Package sign_calc_pkg:
  - mode constants MODE_ADD=2'b00, MODE_SUB=2'b01, MODE_MUL=2'b10, MODE_DIV=2'b11.
  - state encodings ST_IDLE, ST_LOAD, ST_EXEC, ST_DONE.
- Sub-module sign_calc_muldiv (param W):
  - unsigned iterative mul/div core with start/busy/done.
  - outputs product, quotient, remainder.
- Top does sign handling, handshake and output registers.

Test Plan (W=4, OUT_W=9):
- A=5,S[0]=1, B=3,S[1]=0, M=00 -> Cal_out=-2 at cycle 3 after accept; Div_zero=0.
- A=15,S=2'b11, B=15, M=10 -> Cal_out=+225, Out_valid at cycle 6 (W+2). Repeat with S=2'b01 -> -225.
- A=7,S[0]=1, B=2, M=11 -> Cal_out=-3; with SIGN_CALC_REM_EN, Rem_out=-1. A=0,S[0]=1, B=3, M=11 -> Cal_out=0 (no negative zero).
- A=9, B=0, M=11 -> Div_zero=1, Cal_out=0 after 6 cycles. Next op A=1,B=1,M=00 -> Div_zero=0, Cal_out=2.
- Hold Out_ready=0 for 5 cycles in DONE -> Out_valid and Cal_out stable, In_ready=0, new In_valid ignored. Release -> IDLE next cycle.
- Pull Clear_n low mid-EXEC of a mul (cycle 3) -> immediately Out_valid=0, In_ready=1, Cal_out=0. After release, a new add completes correctly.
